// File: rtl/nios_qsys_pio_in_irq.sv
// Avalon-MM input PIO with per-bit synchronizer, debounce filter and
// edge-capture interrupt; register map: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture.
module nios_qsys_pio_in_irq #(
  parameter int               WIDTH     = 4,
  parameter int               DB_CYCLES = 50000,
  parameter int               EDGE      = 1,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] db_data, db_prev;
  logic [CW-1:0]    db_cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask, edge_capture;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= INIT;
      sync2 <= INIT;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after disagreeing with db_data for DB_CYCLES straight cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_data <= INIT;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == db_data[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_data[i] <= sync2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE)
      0:       edges = db_data & ~db_prev;
      1:       edges = ~db_data & db_prev;
      default: edges = db_data ^ db_prev;
    endcase
  end

  assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev      <= INIT;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      db_prev      <= db_data;
      edge_capture <= (edge_capture & ~clr_bits) | edges;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db_data;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_qsys_pio_in_irq.sv
// Directed plus randomized bench for nios_qsys_pio_in_irq (WIDTH=4, DB_CYCLES=4,
// EDGE=falling, INIT=4'hF) with a cycle-level reference model.
module tb_nios_qsys_pio_in_irq;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [3:0] m_s1, m_s2, m_db, m_prev, m_mask, m_cap;
  int         m_run [4];

  nios_qsys_pio_in_irq #(
    .WIDTH(4), .DB_CYCLES(DB), .EDGE(1), .INIT(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF; m_prev = 4'hF;
    m_mask = 4'h0; m_cap = 4'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_db};
      2'd2:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  // One clock of the behavioural model, using the inputs presented before the edge.
  task automatic model_clock();
    logic       wr;
    logic [3:0] falls, clr;
    wr    = chipselect && !write_n;
    falls = m_prev & ~m_db;
    clr   = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
    m_cap = (m_cap & ~clr) | falls;
    if (wr && address == 2'd2) m_mask = writedata[3:0];
    m_prev = m_db;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i]  = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    chk("irq_vs_model", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    chk("readdata_vs_model", readdata, m_read(address));
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    rd(2'd0, 32'h0000000F, "reset_data");
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rd(2'd1, 32'h0, "reset_reserved");
    rd(2'd2, 32'h0, "reset_mask");
    rd(2'd3, 32'h0, "reset_capture");

    // debounce latency and capture on falling bit 0
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    rd(2'd0, 32'hF, "lat_pre");
    ticks(5);
    chk("lat_5_cycles", readdata, 32'hF);
    tick();
    chk("lat_6_cycles", readdata, 32'hE);
    rd(2'd3, 32'h0, "cap_not_yet");
    tick();
    chk("cap_bit0", readdata, 32'h1);
    chk("irq_bit0", {31'h0, irq}, 32'h1);

    // 3-cycle glitch on bit 1 must be filtered
    in_port = 4'hC;
    ticks(3);
    in_port = 4'hE;
    ticks(8);
    rd(2'd0, 32'hE, "glitch_data");
    rd(2'd3, 32'h1, "glitch_capture");

    // clear bit 0 of capture = 3
    in_port = 4'hC;
    ticks(7);
    rd(2'd3, 32'h3, "cap_two_bits");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, "w1c_bit0");
    chk("irq_after_clear", {31'h0, irq}, 32'h0);

    // set beats same-cycle clear on bit 2
    in_port = 4'h8;
    ticks(6);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h6, "set_wins_clear");

    // restore, clear, then reset mid-debounce on bit 3
    in_port = 4'hF;
    ticks(10);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "cleared_all");
    rd(2'd0, 32'hF, "restored_data");
    in_port = 4'h7;
    ticks(4);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'hF, "rst_mid_data");
    rd(2'd2, 32'h0, "rst_mid_mask");
    rd(2'd3, 32'h0, "rst_mid_capture");
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    rd(2'd0, 32'hF, "rst_lat_pre");
    ticks(5);
    chk("rst_lat_5", readdata, 32'hF);
    tick();
    chk("rst_lat_6", readdata, 32'h7);
    rd(2'd3, 32'h0, "rst_cap_pre");
    tick();
    chk("rst_cap_bit3", readdata, 32'h8);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
      address    = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 7) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      tick();
    end
    write_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
